// File: rtl/instr_sequencer.sv
// Purpose: multi-cycle fetch/decode/execute sequencer that drives the IFU next-PC controls and the datapath enables.
// Latency: from the imem_valid cycle to UPDATE inclusive: J/JAL 3 cycles, ALU and branch 4 cycles, LW/SW 4+k cycles (k MEM cycles).
// Backpressure: FETCH holds imem_req until imem_valid, and MEM holds dmem_req until dmem_valid. An illegal opcode parks the block in ERROR until reset.
module instr_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_valid,
    output logic             imem_req,
    input  logic             dmem_valid,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             alu_zero,
    output logic [2:0]       alu_op,
    output logic             reg_we,
    output logic             pc_en,
    output logic             branch,
    output logic             jump,
    output logic [15:0]      imm16,
    output logic [25:0]      targetInstr,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_UPDATE, S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_add, is_sub, is_slt, is_j, is_jal, is_beq, is_bne;
    logic       is_addi, is_xori, is_lw, is_sw, is_ill;
    logic [2:0] op_dec;

    assign opcode      = ir_q[31:26];
    assign funct       = ir_q[5:0];
    assign imm16       = ir_q[15:0];
    assign targetInstr = ir_q[25:0];
    assign retired     = retired_q;
    assign illegal     = (state_q == S_ERROR);

    // Decode the opcode and funct of the held instruction into one-hot class flags.
    always_comb begin
        is_add = 1'b0; is_sub = 1'b0; is_slt = 1'b0; is_j = 1'b0; is_jal = 1'b0;
        is_beq = 1'b0; is_bne = 1'b0; is_addi = 1'b0; is_xori = 1'b0;
        is_lw = 1'b0; is_sw = 1'b0; is_ill = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20:   is_add = 1'b1;
                    6'h22:   is_sub = 1'b1;
                    6'h2A:   is_slt = 1'b1;
                    default: is_ill = 1'b1;
                endcase
            end
            6'h02:   is_j    = 1'b1;
            6'h03:   is_jal  = 1'b1;
            6'h04:   is_beq  = 1'b1;
            6'h05:   is_bne  = 1'b1;
            6'h08:   is_addi = 1'b1;
            6'h0E:   is_xori = 1'b1;
            6'h23:   is_lw   = 1'b1;
            6'h2B:   is_sw   = 1'b1;
            default: is_ill  = 1'b1;
        endcase
    end

    // Select the ALU operation. Add is the fallback, so jumps also decode to 000.
    always_comb begin
        op_dec = 3'b000;
        if (is_sub || is_beq || is_bne) op_dec = 3'b001;
        else if (is_slt)                op_dec = 3'b010;
        else if (is_xori)               op_dec = 3'b011;
    end

    // Compute the next state and the outputs, which decode from state so that reset clears them at once.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        zero_d    = zero_q;
        retired_d = retired_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_we    = 1'b0;
        pc_en     = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        alu_op    = 3'b000;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_ill)              state_d = S_ERROR;
                else if (is_j || is_jal) state_d = S_UPDATE;
                else                     state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_op  = op_dec;
                zero_d  = alu_zero;
                state_d = (is_lw || is_sw) ? S_MEM : S_UPDATE;
            end
            S_MEM: begin
                alu_op   = op_dec;
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_valid) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                alu_op    = op_dec;
                pc_en     = 1'b1;
                reg_we    = is_add || is_sub || is_slt || is_addi || is_xori || is_lw || is_jal;
                branch    = (is_beq && zero_q) || (is_bne && !zero_q);
                jump      = is_j || is_jal;
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    // State register: the async reset aborts any in-flight instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ir_q      <= 32'h0;
            zero_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            zero_q    <= zero_d;
            retired_q <= retired_d;
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Purpose: self-checking bench for instr_sequencer, using a directed vector table, hand-built corner sequences and random instructions against a reference model.
// Latency: expected latencies come from the instruction class, counted from the imem_valid cycle through the pc_en cycle.
// Backpressure: fetch and memory responses are delayed by chosen amounts, and spurious strobes are injected outside their windows.
module tb_instr_sequencer;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [31:0]      imem_rdata = 32'h0;
    logic             imem_valid = 1'b0;
    logic             imem_req;
    logic             dmem_valid = 1'b0;
    logic             dmem_req;
    logic             dmem_we;
    logic             alu_zero = 1'b0;
    logic [2:0]       alu_op;
    logic             reg_we;
    logic             pc_en;
    logic             branch;
    logic             jump;
    logic [15:0]      imm16;
    logic [25:0]      targetInstr;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    instr_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .imem_req(imem_req),
        .dmem_valid(dmem_valid), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .alu_zero(alu_zero), .alu_op(alu_op), .reg_we(reg_we), .pc_en(pc_en),
        .branch(branch), .jump(jump), .imm16(imm16), .targetInstr(targetInstr),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lat;
        bit         reg_we;
        bit         br;
        bit         jmp;
        logic [2:0] op;
        bit         mem;
        bit         dwe;
        bit         ill;
    } exp_t;

    typedef struct {
        logic [31:0] w;
        bit          z;
        int          k;
        exp_t        e;
    } vec_t;

    int               n_checks = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] exp_retired = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference model: the outcome of one instruction follows from its class alone.
    function automatic exp_t model(input logic [31:0] w, input bit z, input int k);
        exp_t       e;
        logic [5:0] op;
        logic [5:0] fn;
        e = '{lat: 4, reg_we: 0, br: 0, jmp: 0, op: 3'd0, mem: 0, dwe: 0, ill: 0};
        op = w[31:26];
        fn = w[5:0];
        case (op)
            6'h00: begin
                if (fn == 6'h20)      begin e.reg_we = 1; e.op = 3'd0; end
                else if (fn == 6'h22) begin e.reg_we = 1; e.op = 3'd1; end
                else if (fn == 6'h2A) begin e.reg_we = 1; e.op = 3'd2; end
                else begin e.ill = 1; e.lat = 0; end
            end
            6'h02: begin e.jmp = 1; e.lat = 3; end
            6'h03: begin e.jmp = 1; e.lat = 3; e.reg_we = 1; end
            6'h04: begin e.op = 3'd1; e.br = z; end
            6'h05: begin e.op = 3'd1; e.br = !z; end
            6'h08: e.reg_we = 1;
            6'h0E: begin e.reg_we = 1; e.op = 3'd3; end
            6'h23: begin e.reg_we = 1; e.mem = 1; e.lat = 4 + k; end
            6'h2B: begin e.mem = 1; e.dwe = 1; e.lat = 4 + k; end
            default: begin e.ill = 1; e.lat = 0; end
        endcase
        return e;
    endfunction

    function automatic vec_t mkv(input logic [31:0] w, input bit z, input int k, input int lat,
                                 input bit we, input bit br, input bit jmp, input logic [2:0] op,
                                 input bit mem, input bit dwe, input bit ill);
        vec_t v;
        v.w = w; v.z = z; v.k = k;
        v.e = '{lat: lat, reg_we: we, br: br, jmp: jmp, op: op, mem: mem, dwe: dwe, ill: ill};
        return v;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_dmem_req", 32'(dmem_req), 0);
        chk("rst_dmem_we", 32'(dmem_we), 0);
        chk("rst_pc_en", 32'(pc_en), 0);
        chk("rst_reg_we", 32'(reg_we), 0);
        chk("rst_branch_jump", 32'({branch, jump}), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_ir", 32'({imm16, targetInstr}), 0);
        exp_retired = '0;
        imem_valid  = 1'b0;
        dmem_valid  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Issue one instruction from its FETCH cycle through UPDATE, or through ERROR for an illegal one.
    task automatic run_instr(input logic [31:0] w, input bit z, input int k, input int fw,
                             input bit noise, input exp_t e);
        int cyc;
        int mem;
        bit seen;
        bit done;
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (imem_req) seen = 1;
        end
        if (!seen) begin
            fail_now("fetch_wait");
            return;
        end
        chk("retired_at_fetch", 32'(retired), 32'(exp_retired));
        for (int t = 0; t < fw; t++) begin
            imem_valid = 1'b0;
            @(negedge clk);
            chk("imem_req_held", 32'(imem_req), 1);
        end
        imem_valid = 1'b1;
        imem_rdata = w;
        alu_zero   = z;
        cyc = 1; mem = 0; done = 0;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            cyc++;
            if (pc_en) begin
                chk("latency", 32'(cyc), 32'(e.lat));
                chk("reg_we", 32'(reg_we), 32'(e.reg_we));
                chk("branch", 32'(branch), 32'(e.br));
                chk("jump", 32'(jump), 32'(e.jmp));
                chk("alu_op", 32'(alu_op), 32'(e.op));
                chk("imm16", 32'(imm16), 32'(w[15:0]));
                chk("targetInstr", 32'(targetInstr), 32'(w[25:0]));
                chk("retired_in_update", 32'(retired), 32'(exp_retired));
                chk("mem_cycles", 32'(mem), e.mem ? 32'(k) : 32'd0);
                exp_retired = exp_retired + 1'b1;
                imem_valid = 1'b0;
                dmem_valid = 1'b0;
                done = 1;
            end else if (illegal) begin
                chk("illegal_expected", 32'(e.ill), 1);
                chk("illegal_cycle", 32'(cyc), 3);
                imem_valid = 1'b0;
                dmem_valid = 1'b0;
                done = 1;
            end else begin
                chk("strobes_outside_update", 32'({reg_we, branch, jump}), 0);
                if (dmem_req) begin
                    mem++;
                    chk("dmem_we", 32'(dmem_we), 32'(e.dwe));
                    dmem_valid = (mem == k);
                end else begin
                    dmem_valid = noise ? 1'($urandom_range(1)) : 1'b0;
                end
                imem_valid = noise ? 1'($urandom_range(1)) : 1'b0;
                imem_rdata = $urandom;
            end
        end
        if (!done) fail_now("instr_complete");
    endtask

    vec_t tbl[15];

    initial begin
        tbl[0]  = mkv(32'h00221820, 0, 0, 4, 1, 0, 0, 3'd0, 0, 0, 0);  // ADD
        tbl[1]  = mkv(32'h00221822, 1, 0, 4, 1, 0, 0, 3'd1, 0, 0, 0);  // SUB
        tbl[2]  = mkv(32'h0022182A, 0, 0, 4, 1, 0, 0, 3'd2, 0, 0, 0);  // SLT
        tbl[3]  = mkv(32'h10220004, 1, 0, 4, 0, 1, 0, 3'd1, 0, 0, 0);  // BEQ taken
        tbl[4]  = mkv(32'h10220004, 0, 0, 4, 0, 0, 0, 3'd1, 0, 0, 0);  // BEQ not taken
        tbl[5]  = mkv(32'h14220004, 0, 0, 4, 0, 1, 0, 3'd1, 0, 0, 0);  // BNE taken
        tbl[6]  = mkv(32'h14220004, 1, 0, 4, 0, 0, 0, 3'd1, 0, 0, 0);  // BNE not taken
        tbl[7]  = mkv(32'h08000190, 0, 0, 3, 0, 0, 1, 3'd0, 0, 0, 0);  // J
        tbl[8]  = mkv(32'h0C000190, 1, 0, 3, 1, 0, 1, 3'd0, 0, 0, 0);  // JAL
        tbl[9]  = mkv(32'h20A50007, 0, 0, 4, 1, 0, 0, 3'd0, 0, 0, 0);  // ADDI
        tbl[10] = mkv(32'h38A50003, 1, 0, 4, 1, 0, 0, 3'd3, 0, 0, 0);  // XORI
        tbl[11] = mkv(32'h8C050008, 0, 3, 7, 1, 0, 0, 3'd0, 1, 0, 0);  // LW, 3 MEM cycles
        tbl[12] = mkv(32'hAC050008, 0, 1, 5, 0, 0, 0, 3'd0, 1, 1, 0);  // SW, 1 MEM cycle
        tbl[13] = mkv(32'h00221821, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 1);  // bad funct
        tbl[14] = mkv(32'hFC000000, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 1);  // bad opcode

        // Power-on reset, then starve the fetch for 5 cycles and reset again mid-FETCH.
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("starve_imem_req", 32'(imem_req), 1);
            chk("starve_pc_en", 32'(pc_en), 0);
            chk("starve_retired", 32'(retired), 0);
        end
        apply_reset();

        // Directed vectors, each with a zero-wait fetch.
        for (int i = 0; i < 15; i++) begin
            run_instr(tbl[i].w, tbl[i].z, tbl[i].k, 0, 0, tbl[i].e);
            if (tbl[i].e.ill) apply_reset();
        end

        // ERROR is absorbing: fetch strobes are ignored and retired holds.
        run_instr(32'h00221820, 0, 0, 1, 0, tbl[0].e);
        run_instr(32'hFC000000, 0, 0, 0, 0, tbl[14].e);
        for (int i = 0; i < 6; i++) begin
            imem_valid = 1'b1;
            imem_rdata = 32'h00221820;
            @(negedge clk);
            chk("err_pc_en", 32'(pc_en), 0);
            chk("err_imem_req", 32'(imem_req), 0);
            chk("err_illegal", 32'(illegal), 1);
            chk("err_retired", 32'(retired), 32'(exp_retired));
        end
        apply_reset();

        // A reset between DECODE and EXEC aborts the instruction without retiring it.
        run_instr(32'h00221820, 0, 0, 0, 0, tbl[0].e);
        @(negedge clk);
        imem_valid = 1'b1;
        imem_rdata = 32'h00221822;
        @(negedge clk);
        imem_valid = 1'b0;
        chk("abort_decode_pc_en", 32'(pc_en), 0);
        apply_reset();
        run_instr(32'h00221820, 0, 0, 0, 0, tbl[0].e);

        // Random instructions with fetch and memory delays and spurious strobes.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] w;
            logic [5:0]  ops[11];
            int          sel;
            bit          z;
            int          k;
            exp_t        e;
            ops = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0E, 6'h23, 6'h2B};
            w   = $urandom;
            sel = int'($urandom_range(19));
            if (sel < 19) begin
                w[31:26] = ops[sel % 11];
                if (sel % 11 == 0)      w[5:0] = 6'h20;
                else if (sel % 11 == 1) w[5:0] = 6'h22;
                else if (sel % 11 == 2) w[5:0] = 6'h2A;
            end
            z = 1'($urandom_range(1));
            k = 1 + int'($urandom_range(3));
            e = model(w, z, k);
            run_instr(w, z, k, int'($urandom_range(2)), 1, e);
            if (e.ill) apply_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
